axis_pkt_arbiter: RTL
=====================

Name: axis_pkt_arbiter

Overview:
- Two-input, packet-granular, round-robin arbiter for the 256-bit AXI-Stream datapath.
- Merges streams S0 and S1 onto a single master stream M, which feeds the stream pass-through/loopback stage.
- Once a packet is granted, it stays granted until its TLAST beat is accepted. Packets are never interleaved.
- The output is one registered stage that sustains full throughput.

Parameters:
- DATA_WIDTH, 256, TDATA width in bits.
- KEEP_WIDTH, 32, TKEEP width. Must equal DATA_WIDTH/8.

Ports:
- ACLK  in  1  single clock. All logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S0_AXIS_TDATA  in  DATA_WIDTH  port-0 data.
- S0_AXIS_TKEEP  in  KEEP_WIDTH  port-0 byte enables.
- S0_AXIS_TVALID  in  1  port-0 valid.
- S0_AXIS_TLAST  in  1  port-0 end of packet.
- S0_AXIS_TREADY  out  1  port-0 ready.
- S1_AXIS_TDATA, S1_AXIS_TKEEP, S1_AXIS_TVALID, S1_AXIS_TLAST, S1_AXIS_TREADY: same as port 0, for port 1.
- M_AXIS_TDATA  out  DATA_WIDTH  merged data.
- M_AXIS_TKEEP  out  KEEP_WIDTH  merged byte enables.
- M_AXIS_TVALID  out  1  merged valid.
- M_AXIS_TLAST  out  1  merged end of packet.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TID  out  1  source port of the current output beat.
- GRANT  out  2  one-hot current grant (bit0 = S0, bit1 = S1). 00 when idle.

Behaviour:
- Clock and reset: one clock, ACLK; reset is synchronous and active-high, port ARESET.
- Reset values, applied on the next ACLK edge while ARESET=1:
  - state=IDLE, GRANT=00, last_served=1 (so S0 wins the first tie).
  - M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TKEEP=0, M_AXIS_TLAST=0, M_AXIS_TID=0.
  - S0_AXIS_TREADY=0, S1_AXIS_TREADY=0.
- Reset mid-packet: the packet is abandoned, the output register is cleared, and arbitration restarts from IDLE.
- Beat accounting:
  - acc_n = Sn_AXIS_TVALID & Sn_AXIS_TREADY.
  - out_free = !M_AXIS_TVALID | M_AXIS_TREADY.
- FSM states: IDLE, BUSY0, BUSY1.
  - IDLE:
    - Both S*_TREADY=0.
    - Only S0_TVALID=1 -> BUSY0. Only S1_TVALID=1 -> BUSY1.
    - Both valid -> grant the port != last_served.
    - Neither valid -> stay in IDLE.
    - Arbitration takes one cycle; no beat is accepted in IDLE.
  - BUSYn:
    - Sn_AXIS_TREADY = out_free (combinational); the other port's TREADY=0.
    - Each acc_n loads TDATA/TKEEP/TLAST into the output register, sets M_TVALID=1 and M_TID=n.
    - acc_n with TLAST=1 -> last_served=n, next state IDLE.
- Output register:
  - If M_TREADY=1 and no acc in the same cycle, M_TVALID clears to 0.
  - Simultaneous drain and load keeps M_TVALID=1 with the new beat (no bubble).
  - While M_TVALID=1 and M_TREADY=0, all M_* outputs hold stable (AXI-Stream rule).
- Latency:
  - First beat appears on M two cycles after Sn_TVALID rises from IDLE (arbitration cycle + register).
  - Streaming inside a packet: 1 beat/cycle, 1-cycle latency.
  - Between packets: exactly one idle arbitration cycle (IDLE state).
- GRANT = 01 in BUSY0, 10 in BUSY1, 00 in IDLE. Registered.
- Boundaries:
  - Single-beat packet (TVALID and TLAST in the first beat) returns to IDLE after 1 acc.
  - TVALID dropping mid-packet does not release the grant; the arbiter waits on that port indefinitely.
  - The non-granted port's TVALID is ignored and its data is never sampled.
  - TKEEP is passed through unmodified; there is no checking.

Test Plan:
- Reset: hold ARESET=1 for 3 cycles with both S*_TVALID=1 -> all M_* =0, both TREADY=0, GRANT=00. First grant after release goes to S0.
- Single source: S1 sends a 4-beat packet, data 0x1..0x4, M_TREADY=1 -> M shows 0x1..0x4 on consecutive cycles starting 2 cycles after S1_TVALID, TLAST on 0x4, TID=1, GRANT=10, then 00.
- Fairness: both ports continuously offer 2-beat packets (S0 data 0xA*, S1 data 0xB*) -> output order S0,S1,S0,S1. One idle cycle between packets, no interleaving within a packet.
- Backpressure: M_TREADY toggles 1,0,0,1 during a 3-beat S0 packet -> M_TDATA/TLAST held stable while stalled, S0_TREADY=0 when out_free=0, no beat lost or duplicated.
- Single-beat packets: S0 and S1 each send 1-beat packets with TLAST=1 -> alternating grants, each beat has the correct TID, and the FSM returns to IDLE after each.
- Reset mid-packet: assert ARESET after beat 2 of a 5-beat S1 packet -> next cycle M_TVALID=0, GRANT=00. A new S0 packet after release is granted and forwarded intact.

Source files
------------

// File: rtl/axis_pkt_arbiter.sv
// Two-input, packet-granular round-robin arbiter for a 256-bit AXI-Stream datapath.
// A granted packet owns the single registered output stage until its TLAST beat is accepted.
module axis_pkt_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,

  input  logic [DATA_WIDTH-1:0] S0_AXIS_TDATA,
  input  logic [KEEP_WIDTH-1:0] S0_AXIS_TKEEP,
  input  logic                  S0_AXIS_TVALID,
  input  logic                  S0_AXIS_TLAST,
  output logic                  S0_AXIS_TREADY,

  input  logic [DATA_WIDTH-1:0] S1_AXIS_TDATA,
  input  logic [KEEP_WIDTH-1:0] S1_AXIS_TKEEP,
  input  logic                  S1_AXIS_TVALID,
  input  logic                  S1_AXIS_TLAST,
  output logic                  S1_AXIS_TREADY,

  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [KEEP_WIDTH-1:0] M_AXIS_TKEEP,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TID,

  output logic [1:0]            GRANT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_served_q, last_served_d;
  logic [1:0]            grant_q, grant_d;

  logic [DATA_WIDTH-1:0] m_data_q;
  logic [KEEP_WIDTH-1:0] m_keep_q;
  logic                  m_valid_q;
  logic                  m_last_q;
  logic                  m_tid_q;

  logic                  out_free;
  logic                  s0_ready;
  logic                  s1_ready;
  logic                  acc0;
  logic                  acc1;

  // The output slot is free when empty or being drained this cycle.
  assign out_free = !m_valid_q || M_AXIS_TREADY;
  assign s0_ready = (state_q == BUSY0) && out_free;
  assign s1_ready = (state_q == BUSY1) && out_free;
  assign acc0     = S0_AXIS_TVALID && s0_ready;
  assign acc1     = S1_AXIS_TVALID && s1_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d       = state_q;
    last_served_d = last_served_q;
    grant_d       = 2'b00;

    unique case (state_q)
      IDLE: begin
        // On a tie, the port that was not served last wins.
        if (S0_AXIS_TVALID && (!S1_AXIS_TVALID || last_served_q)) begin
          state_d = BUSY0;
        end else if (S1_AXIS_TVALID) begin
          state_d = BUSY1;
        end
      end
      BUSY0: begin
        if (acc0 && S0_AXIS_TLAST) begin
          state_d       = IDLE;
          last_served_d = 1'b0;
        end
      end
      BUSY1: begin
        if (acc1 && S1_AXIS_TLAST) begin
          state_d       = IDLE;
          last_served_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    grant_d = {state_d == BUSY1, state_d == BUSY0};
  end

  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (ARESET) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      grant_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      grant_q       <= grant_d;
    end
  end

  always_ff @(posedge ACLK) begin
    // NOTE: the datapath register is reset too, because the output must read all-zero after reset.
    if (ARESET) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_tid_q   <= 1'b0;
    end else if (acc0) begin
      m_valid_q <= 1'b1;
      m_data_q  <= S0_AXIS_TDATA;
      m_keep_q  <= S0_AXIS_TKEEP;
      m_last_q  <= S0_AXIS_TLAST;
      m_tid_q   <= 1'b0;
    end else if (acc1) begin
      m_valid_q <= 1'b1;
      m_data_q  <= S1_AXIS_TDATA;
      m_keep_q  <= S1_AXIS_TKEEP;
      m_last_q  <= S1_AXIS_TLAST;
      m_tid_q   <= 1'b1;
    end else if (M_AXIS_TREADY) begin
      m_valid_q <= 1'b0;
    end
  end

  assign S0_AXIS_TREADY = s0_ready;
  assign S1_AXIS_TREADY = s1_ready;
  assign M_AXIS_TDATA   = m_data_q;
  assign M_AXIS_TKEEP   = m_keep_q;
  assign M_AXIS_TVALID  = m_valid_q;
  assign M_AXIS_TLAST   = m_last_q;
  assign M_AXIS_TID     = m_tid_q;
  assign GRANT          = grant_q;

endmodule
